// File: rtl/safe_pkg.sv
// Shared types and widths for the digital safe: FSM state encoding plus
// digit/code geometry used by the lock controller and the display layer.
package safe_pkg;

    localparam int STATE_W       = 3;
    localparam int SAFE_DIGIT_W  = 4;
    localparam int SAFE_CODE_LEN = 4;
    localparam int SAFE_CODE_W   = SAFE_CODE_LEN * SAFE_DIGIT_W;

    typedef enum logic [STATE_W-1:0] {
        ST_ENTRY    = 3'd0,
        ST_CHECK    = 3'd1,
        ST_UNLOCKED = 3'd2,
        ST_SET_CODE = 3'd3,
        ST_LOCKOUT  = 3'd4
    } state_e;

endpackage

// File: rtl/lockout_timer.sv
// Lockout interval timer: restarts from zero on start and pulses done for one
// cycle after LOCKOUT_CYCLES counting cycles have elapsed.
module lockout_timer #(
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic sys_reset_n,
    input  logic start,
    output logic done
);

    localparam int CNT_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LOCKOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_r;
    logic             running_r;

    // Count register; done is registered so the FSM leaves one cycle after the last count.
    always_ff @(posedge clk) begin
        if (!sys_reset_n) begin
            count_r   <= {CNT_W{1'b0}};
            running_r <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                count_r   <= {CNT_W{1'b0}};
                running_r <= 1'b1;
            end else if (running_r) begin
                if (count_r == LAST) begin
                    running_r <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    count_r <= count_r + CNT_W'(1);
                end
            end else begin
                count_r <= count_r;
            end
        end
    end

endmodule

// File: rtl/safe_lock_controller.sv
// Digital safe sequencer: digit buffering, code compare, attempt counting,
// lockout and re-programming of the stored code while unlocked.
module safe_lock_controller
    import safe_pkg::*;
#(
    parameter int CODE_LEN       = SAFE_CODE_LEN,
    parameter int DIGIT_W        = SAFE_DIGIT_W,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {(CODE_LEN*DIGIT_W){1'b0}}
) (
    input  logic                              clk,
    input  logic                              sys_reset_n,
    input  logic                              store_digit_pulse,
    input  logic [DIGIT_W-1:0]                digit_in,
    input  logic                              confirm_pulse,
    input  logic                              clear_pulse,
    input  logic                              lock_pulse,
    input  logic                              set_code_pulse,
    output logic                              enable_entry,
    output logic                              unlocked,
    output logic                              alarm,
    output logic [$clog2(CODE_LEN+1)-1:0]     digit_count,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
    output logic [STATE_W-1:0]                state_code
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam logic [CNT_W-1:0] FULL    = CNT_W'(CODE_LEN);
    localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_ATTEMPTS);

    state_e            state_r, state_s;
    logic [CODE_W-1:0] buf_r, buf_s;
    logic [CODE_W-1:0] code_r, code_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [ATT_W-1:0]  att_r, att_s;
    logic              start_s;
    logic              done_s;
    logic              match_s;

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk         (clk),
        .sys_reset_n (sys_reset_n),
        .start       (start_s),
        .done        (done_s)
    );

    // An incomplete buffer never matches, even if its zero padding equals the code.
    assign match_s = (cnt_r == FULL) && (buf_r == code_r);

    // Next-state, buffer, stored-code and attempt-counter logic.
    always_comb begin
        state_s = state_r;
        buf_s   = buf_r;
        code_s  = code_r;
        cnt_s   = cnt_r;
        att_s   = att_r;
        start_s = 1'b0;
        case (state_r)
            ST_ENTRY, ST_SET_CODE: begin
                if (clear_pulse) begin
                    buf_s = {CODE_W{1'b0}};
                    cnt_s = {CNT_W{1'b0}};
                end else if (confirm_pulse) begin
                    if (state_r == ST_ENTRY) begin
                        state_s = ST_CHECK;
                    end else begin
                        if (cnt_r == FULL) begin
                            code_s = buf_r;
                        end else begin
                            code_s = code_r;
                        end
                        buf_s   = {CODE_W{1'b0}};
                        cnt_s   = {CNT_W{1'b0}};
                        state_s = ST_UNLOCKED;
                    end
                end else if (store_digit_pulse && (cnt_r < FULL)) begin
                    buf_s = (buf_r << DIGIT_W) | CODE_W'(digit_in);
                    cnt_s = cnt_r + CNT_W'(1);
                end else begin
                    buf_s = buf_r;
                end
            end
            ST_CHECK: begin
                buf_s = {CODE_W{1'b0}};
                cnt_s = {CNT_W{1'b0}};
                if (match_s) begin
                    att_s   = ATT_MAX;
                    state_s = ST_UNLOCKED;
                end else if (att_r > ATT_W'(1)) begin
                    att_s   = att_r - ATT_W'(1);
                    state_s = ST_ENTRY;
                end else begin
                    att_s   = {ATT_W{1'b0}};
                    state_s = ST_LOCKOUT;
                    start_s = 1'b1;
                end
            end
            ST_UNLOCKED: begin
                if (lock_pulse) begin
                    state_s = ST_ENTRY;
                end else if (set_code_pulse) begin
                    state_s = ST_SET_CODE;
                end else begin
                    state_s = ST_UNLOCKED;
                end
            end
            ST_LOCKOUT: begin
                if (done_s) begin
                    att_s   = ATT_MAX;
                    state_s = ST_ENTRY;
                end else begin
                    state_s = ST_LOCKOUT;
                end
            end
            default: begin
                state_s = ST_ENTRY;
                buf_s   = {CODE_W{1'b0}};
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers; flag outputs are decoded from the next state so they move with it.
    always_ff @(posedge clk) begin
        if (!sys_reset_n) begin
            state_r      <= ST_ENTRY;
            buf_r        <= {CODE_W{1'b0}};
            code_r       <= DEFAULT_CODE;
            cnt_r        <= {CNT_W{1'b0}};
            att_r        <= ATT_MAX;
            enable_entry <= 1'b1;
            unlocked     <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state_r      <= state_s;
            buf_r        <= buf_s;
            code_r       <= code_s;
            cnt_r        <= cnt_s;
            att_r        <= att_s;
            enable_entry <= (state_s == ST_ENTRY) || (state_s == ST_SET_CODE);
            unlocked     <= (state_s == ST_UNLOCKED) || (state_s == ST_SET_CODE);
            alarm        <= (state_s == ST_LOCKOUT);
        end
    end

    assign digit_count   = cnt_r;
    assign attempts_left = att_r;
    assign state_code    = state_r;

endmodule
